// File: rtl/data_upload_pkg.sv
// Shared constants and types for the SPI upload (transmit) path of the file channel.
package data_upload_pkg;

    localparam logic [7:0] CMD_START = 8'h60;
    localparam logic [7:0] CMD_DATA  = 8'h61;
    localparam logic [7:0] CMD_END   = 8'h62;

    typedef enum logic [1:0] {IDLE, INDEX, DATA, IGNORE} state_e;

    typedef enum logic [1:0] {EDGE_NONE, EDGE_RISE, EDGE_FALL} sck_edge_e;

endpackage

// File: rtl/data_upload_if.sv
// ioctl-style read port between the upload block (master) and core memory (slave).
interface data_upload_if #(
    parameter int ADDR_WIDTH = 25
);
    logic                  ioctl_upload;
    logic [7:0]            ioctl_index;
    logic [ADDR_WIDTH-1:0] ioctl_addr;
    logic                  ioctl_rd;
    logic [7:0]            ioctl_din;

    modport master (
        output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
        output ioctl_din
    );
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizers for SCK/SS/DI into clk_sys, with SCK edge pulses.
module spi_sync_edge
    import data_upload_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      sck,
    input  logic      ss,
    input  logic      di,
    output sck_edge_e sck_edge,
    output logic      ss_s,
    output logic      di_s
);
    logic [1:0] sck_q, sck_d, ss_q, ss_d, di_q, di_d;
    logic       sck_prev_q, sck_prev_d;

    always_comb begin
        sck_d      = {sck_q[0], sck};
        ss_d       = {ss_q[0], ss};
        di_d       = {di_q[0], di};
        sck_prev_d = sck_q[1];
    end

    // Presets model an idle bus: SCK low, chip select deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= 2'b00;
            ss_q       <= 2'b11;
            di_q       <= 2'b00;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= sck_d;
            ss_q       <= ss_d;
            di_q       <= di_d;
            sck_prev_q <= sck_prev_d;
        end
    end

    always_comb begin
        sck_edge = EDGE_NONE;
        if (sck_q[1] && !sck_prev_q)      sck_edge = EDGE_RISE;
        else if (!sck_q[1] && sck_prev_q) sck_edge = EDGE_FALL;
    end

    assign ss_s = ss_q[1];
    assign di_s = di_q[1];

endmodule

// File: rtl/data_upload.sv
// SPI slave that streams a core memory region back to the IO controller on SPI_DO,
// fetching bytes one ahead through the ioctl read port.
module data_upload
    import data_upload_pkg::*;
#(
    parameter int         ADDR_WIDTH = 25,
    parameter int         RD_LATENCY = 2,
    parameter logic [7:0] CMD_START  = data_upload_pkg::CMD_START,
    parameter logic [7:0] CMD_DATA   = data_upload_pkg::CMD_DATA,
    parameter logic [7:0] CMD_END    = data_upload_pkg::CMD_END
) (
    input  logic               clk_sys,
    input  logic               res_n,
    input  logic               SPI_SCK,
    input  logic               SPI_SS2,
    input  logic               SPI_DI,
    output logic               spi_do,
    output logic               spi_do_oe,
    data_upload_if.master      ioctl
);
    sck_edge_e sck_edge;
    logic      ss_s, di_s;

    spi_sync_edge u_sync (
        .clk      (clk_sys),
        .rst_n    (res_n),
        .sck      (SPI_SCK),
        .ss       (SPI_SS2),
        .di       (SPI_DI),
        .sck_edge (sck_edge),
        .ss_s     (ss_s),
        .di_s     (di_s)
    );

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            rx_q, rx_d, tx_q, tx_d, tx_next_q, tx_next_d;
    logic [7:0]            pref_q, pref_d, index_q, index_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  upload_q, upload_d, load_pend_q, load_pend_d;
    logic [RD_LATENCY:0]   vld_pipe_q, vld_pipe_d;

    logic       rise, fall, byte_done, fetch_req;
    logic [7:0] rx_byte;

    assign rise      = (sck_edge == EDGE_RISE) && !ss_s;
    assign fall      = (sck_edge == EDGE_FALL) && !ss_s;
    assign byte_done = rise && (cnt_q == 3'd7);
    assign rx_byte   = {rx_q[6:0], di_s};

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ss_s) begin
            state_d = IDLE;
        end else if (byte_done) begin
            case (state_q)
                IDLE:    if (rx_byte == CMD_START)     state_d = INDEX;
                         else if (rx_byte == CMD_DATA) state_d = DATA;
                         else                          state_d = IGNORE;
                INDEX:   state_d = IGNORE;
                DATA:    state_d = DATA;
                default: state_d = IGNORE;
            endcase
        end
    end

    always_comb begin
        spi_do_oe = (state_q == DATA);
        spi_do    = (state_q == DATA) ? tx_q[7] : 1'b0;
        fetch_req = byte_done && upload_q &&
                    (state_q == DATA || (state_q == IDLE && rx_byte == CMD_DATA));
    end

    // tx_next holds the byte for the coming transfer; it is taken from the prefetch
    // before this boundary's fetch lands, which is what makes the stream lag by one.
    always_comb begin
        cnt_d       = ss_s ? 3'd0 : (rise ? cnt_q + 3'd1 : cnt_q);
        rx_d        = ss_s ? 8'h00 : (rise ? rx_byte : rx_q);
        vld_pipe_d  = {vld_pipe_q[RD_LATENCY-1:0], fetch_req};
        pref_d      = pref_q;
        addr_d      = addr_q;
        upload_d    = upload_q;
        index_d     = index_q;
        tx_next_d   = tx_next_q;
        load_pend_d = load_pend_q;
        tx_d        = tx_q;

        if (vld_pipe_q[RD_LATENCY]) begin
            pref_d = ioctl.ioctl_din;
            addr_d = addr_q + ADDR_WIDTH'(1);
        end

        if (byte_done) begin
            load_pend_d = 1'b1;
            case (state_q)
                IDLE: begin
                    tx_next_d = 8'h00;
                    if (rx_byte == CMD_END) upload_d = 1'b0;
                end
                INDEX: begin
                    index_d  = rx_byte;
                    addr_d   = '0;
                    upload_d = 1'b1;
                end
                DATA:    tx_next_d = upload_q ? pref_q : 8'h00;
                default: ;
            endcase
        end

        if (ss_s) begin
            load_pend_d = 1'b0;
            tx_d        = 8'h00;
        end else if (fall && state_q == DATA) begin
            tx_d        = load_pend_q ? tx_next_q : {tx_q[6:0], 1'b0};
            load_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            cnt_q       <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            tx_next_q   <= 8'h00;
            pref_q      <= 8'h00;
            index_q     <= 8'h00;
            addr_q      <= '0;
            upload_q    <= 1'b0;
            load_pend_q <= 1'b0;
            vld_pipe_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            tx_next_q   <= tx_next_d;
            pref_q      <= pref_d;
            index_q     <= index_d;
            addr_q      <= addr_d;
            upload_q    <= upload_d;
            load_pend_q <= load_pend_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    assign ioctl.ioctl_upload = upload_q;
    assign ioctl.ioctl_index  = index_q;
    assign ioctl.ioctl_addr   = addr_q;
    assign ioctl.ioctl_rd     = vld_pipe_q[0];

endmodule

// File: tb/tb_data_upload.sv
// Randomized SPI frames against a frame-level model of the upload protocol.
module tb_data_upload;
    localparam int AW  = 4;
    localparam int LAT = 2;

    logic clk_sys = 1'b0;
    logic res_n   = 1'b1;
    logic sck     = 1'b0;
    logic ss      = 1'b1;
    logic di      = 1'b0;
    logic spi_do, spi_do_oe;

    data_upload_if #(.ADDR_WIDTH(AW)) ioctl ();

    data_upload #(.ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
        .clk_sys   (clk_sys),
        .res_n     (res_n),
        .SPI_SCK   (sck),
        .SPI_SS2   (ss),
        .SPI_DI    (di),
        .spi_do    (spi_do),
        .spi_do_oe (spi_do_oe),
        .ioctl     (ioctl.master)
    );

    always #10 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] mem(input logic [AW-1:0] a);
        return 8'(a) ^ 8'hA5;
    endfunction

    // Memory: data valid only in the cycle RD_LATENCY after the strobe, garbage otherwise.
    int            rcnt = 0;
    logic [AW-1:0] ra   = '0;
    always @(posedge clk_sys) begin
        if (ioctl.ioctl_rd === 1'b1) begin
            rcnt = 1;
            ra   = ioctl.ioctl_addr;
        end else if (rcnt != 0) begin
            rcnt = rcnt + 1;
        end
        if (rcnt == LAT) ioctl.ioctl_din <= mem(ra);
        else             ioctl.ioctl_din <= 8'($urandom);
        if (rcnt > LAT) rcnt = 0;
    end

    logic [AW-1:0] rdq[$];
    always @(posedge clk_sys)
        if (ioctl.ioctl_rd === 1'b1) rdq.push_back(ioctl.ioctl_addr);

    logic          m_upload = 1'b0;
    logic [7:0]    m_index  = 8'h00;
    logic [AW-1:0] m_addr   = '0;
    logic [7:0]    frm[$];

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic int ph();
        return LAT + 6 + int'($urandom_range(0, 4));
    endfunction

    // Mode 0 master: drive DI while SCK low, sample MISO just before the rising edge.
    task automatic spi_xfer(input logic [7:0] mo, input int nb,
                            output logic [7:0] mi, output logic oe);
        mi = 8'h00;
        oe = 1'b0;
        for (int b = 0; b < nb; b++) begin
            di = mo[7-b];
            wait_cyc(ph());
            if (b == 0) oe = spi_do_oe;
            mi  = {mi[6:0], spi_do};
            sck = 1'b1;
            wait_cyc(ph());
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int part);
        logic [7:0]    miso[$];
        logic          oes[$];
        logic [7:0]    mb, exp_b;
        logic          oe, up0, is_data;
        logic [AW-1:0] base;
        logic [AW-1:0] exp_rd[$];
        rdq.delete();
        ss = 1'b0;
        wait_cyc(LAT + 8);
        foreach (frm[i]) begin
            spi_xfer(frm[i], 8, mb, oe);
            miso.push_back(mb);
            oes.push_back(oe);
        end
        if (part > 0) spi_xfer(8'($urandom), part, mb, oe);
        wait_cyc(3);
        ss = 1'b1;
        wait_cyc(LAT + 12);

        base    = m_addr;
        up0     = m_upload;
        is_data = (frm[0] == 8'h61);
        if (frm[0] == 8'h60 && frm.size() >= 2) begin
            m_index  = frm[1];
            m_addr   = '0;
            m_upload = 1'b1;
        end else if (frm[0] == 8'h62) begin
            m_upload = 1'b0;
        end else if (is_data && up0) begin
            for (int j = 0; j < frm.size(); j++) exp_rd.push_back(base + AW'(j));
            m_addr = base + AW'(frm.size());
        end

        for (int k = 0; k < frm.size(); k++) begin
            exp_b = (is_data && up0 && k >= 2) ? mem(base + AW'(k - 2)) : 8'h00;
            chk("miso_byte", 32'(miso[k]), 32'(exp_b));
            chk("oe_in_byte", 32'(oes[k]), 32'(is_data && k >= 1));
        end
        chk("rd_count", 32'(rdq.size()), 32'(exp_rd.size()));
        for (int j = 0; j < exp_rd.size() && j < rdq.size(); j++)
            chk("rd_addr", 32'(rdq[j]), 32'(exp_rd[j]));
        chk("upload", 32'(ioctl.ioctl_upload), 32'(m_upload));
        chk("index", 32'(ioctl.ioctl_index), 32'(m_index));
        chk("addr", 32'(ioctl.ioctl_addr), 32'(m_addr));
        chk("oe_idle", 32'(spi_do_oe), 32'(0));
    endtask

    initial begin
        logic [7:0] mb, b;
        logic       oe;
        #5 res_n = 1'b0;
        wait_cyc(3);
        chk("rst_oe", 32'(spi_do_oe), 32'(0));
        chk("rst_do", 32'(spi_do), 32'(0));
        chk("rst_upload", 32'(ioctl.ioctl_upload), 32'(0));
        chk("rst_index", 32'(ioctl.ioctl_index), 32'(0));
        chk("rst_addr", 32'(ioctl.ioctl_addr), 32'(0));
        chk("rst_rd", 32'(ioctl.ioctl_rd), 32'(0));
        res_n = 1'b1;
        wait_cyc(5);

        frm = {8'h60, 8'h05};            run_frame(0);
        frm = {8'h61, 8'h11, 8'h22, 8'h33}; run_frame(0);
        frm = {8'h61, 8'h44, 8'h55};     run_frame(0);
        frm = {8'h62};                   run_frame(0);
        frm = {8'h61, 8'h01, 8'h02, 8'h03}; run_frame(0);

        for (int f = 0; f < 10; f++) begin
            case ($urandom_range(0, 3))
                0: frm = {8'h60, 8'($urandom)};
                1: begin
                    frm = {8'h61};
                    repeat ($urandom_range(1, 4)) frm.push_back(8'($urandom));
                end
                2: frm = {8'h62, 8'($urandom)};
                default: begin
                    b = 8'($urandom);
                    if (b >= 8'h60 && b <= 8'h62) b = 8'h7F;
                    frm = {b, 8'($urandom)};
                end
            endcase
            run_frame(0);
        end

        // Drive the address to 15, then abort a data byte after three bits.
        frm = {8'h60, 8'hC3};
        run_frame(0);
        frm = {8'h61};
        repeat (14) frm.push_back(8'($urandom));
        run_frame(0);
        chk("addr_at_15", 32'(ioctl.ioctl_addr), 32'(15));
        frm = {8'h61};
        run_frame(3);
        chk("addr_wrapped", 32'(ioctl.ioctl_addr), 32'(0));
        frm = {8'h61, 8'h9E, 8'h10};
        run_frame(0);

        // Asynchronous reset in the middle of a data byte.
        frm = {8'h60, 8'h3C};
        run_frame(0);
        ss = 1'b0;
        wait_cyc(LAT + 8);
        spi_xfer(8'h61, 8, mb, oe);
        spi_xfer(8'hFF, 3, mb, oe);
        chk("oe_before_rst", 32'(spi_do_oe), 32'(1));
        res_n = 1'b0;
        #1;
        chk("arst_oe", 32'(spi_do_oe), 32'(0));
        chk("arst_upload", 32'(ioctl.ioctl_upload), 32'(0));
        chk("arst_rd", 32'(ioctl.ioctl_rd), 32'(0));
        chk("arst_do", 32'(spi_do), 32'(0));
        ss = 1'b1;
        wait_cyc(5);
        res_n = 1'b1;
        m_upload = 1'b0;
        m_index  = 8'h00;
        m_addr   = '0;
        wait_cyc(5);
        frm = {8'h60, 8'h5A};            run_frame(0);
        frm = {8'h61, 8'h00, 8'h00};     run_frame(0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
